controlador_iluminacao: RTL and testbench
=========================================

Name: controlador_iluminacao

Overview:
Top-level lighting controller for the smart lighting system. It debounces the wall push-button, selects MANUAL or AUTO mode, sequences the external auto-shutdown timer (holds it cleared or releases it, and consumes its expiry pulse), and drives the lamp through a soft-start/soft-stop brightness ramp with PWM output. All lamp on/off decisions are made here; the timer only reports absence timeouts.

Parameters:
DEBOUNCE_T, 50, cycles push_button must be stable before a level change is accepted
LONG_PRESS_T, 3000, debounced-press duration (cycles) that counts as a long press
RAMP_STEP_T, 100, cycles between brightness steps while ramping
PWM_BITS, 8, width of brightness and PWM counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
push_button  in  1  raw button, 1 = pressed, asynchronous
infravermelho  in  1  presence sensor, 1 = presence, asynchronous
ldr_escuro  in  1  ambient dark flag, 1 = dark, asynchronous
timer_expira  in  1  one-cycle pulse from the auto-shutdown timer (absence timeout)
timer_clr  out  1  1 = hold the auto-shutdown timer cleared
lampada  out  1  PWM lamp drive
brilho  out  PWM_BITS  current brightness level
modo_auto  out  1  1 = AUTO mode, 0 = MANUAL
lamp_ativa  out  1  1 in SUBINDO or LIGADA

Behaviour:
- Reset: clk is clk, rst is rst, asynchronous, active-high. All outputs 0 except timer_clr = 1; state DESLIGADA, modo_auto = 0, all counters 0.
- Inputs push_button, infravermelho, ldr_escuro pass through 2-FF synchronizers (2-cycle latency); timer_expira is synchronous, used directly.
- Debounce: counter restarts on every change of the synchronized button; debounced level updates when the new level has held for DEBOUNCE_T consecutive cycles.
- Press classification: hold counter runs while debounced level = 1, saturating at LONG_PRESS_T. When count reaches LONG_PRESS_T: one-cycle long_evt (fires once per press). On release with count < LONG_PRESS_T: one-cycle short_evt. Release after long_evt produces nothing.
- long_evt toggles modo_auto. Entering MANUAL keeps lamp state; entering AUTO with lamp off leaves it off until presence.
- Lamp FSM states: DESLIGADA, SUBINDO, LIGADA, DESCENDO.
  on_req = short_evt while lamp off/descending (either mode), or (modo_auto & infravermelho & ldr_escuro) while DESLIGADA/DESCENDO.
  off_req = short_evt while SUBINDO/LIGADA, or (modo_auto & timer_expira) while SUBINDO/LIGADA.
  DESLIGADA -on_req-> SUBINDO; SUBINDO -brilho max-> LIGADA; SUBINDO/LIGADA -off_req-> DESCENDO; DESCENDO -brilho 0-> DESLIGADA; DESCENDO -on_req-> SUBINDO.
  Reversal keeps current brilho (no jump). short_evt and timer_expira in same cycle: short_evt wins (single off_req, no double toggle).
- Ramp: step counter counts RAMP_STEP_T cycles then brilho ±1; step counter cleared on every state change. brilho saturates at 0 and 2^PWM_BITS-1, never wraps. Full ramp 0->max = (2^PWM_BITS-1)*RAMP_STEP_T cycles.
- timer_clr = 0 only when modo_auto = 1 and state is SUBINDO or LIGADA; otherwise 1. timer_expira ignored while timer_clr = 1 or in MANUAL.
- PWM: free-running PWM_BITS counter; lampada = (pwm_cnt < brilho), except brilho = max forces lampada = 1; brilho = 0 gives lampada = 0 constantly. Registered output.
- Reset mid-ramp: immediate return to reset values, no ramp-down.

Test Plan:
DEBOUNCE_T=4, LONG_PRESS_T=20, RAMP_STEP_T=2: 3-cycle glitch on push_button -> no short_evt, state stays DESLIGADA, brilho 0.
Clean 10-cycle press in MANUAL -> SUBINDO, brilho reaches 255 after 510 cycles, LIGADA, lampada constant 1; second press -> DESCENDO to 0, DESLIGADA.
30-cycle press -> modo_auto toggles 0->1 exactly once, lamp unchanged; infravermelho=1, ldr_escuro=1 -> SUBINDO, timer_clr drops to 0.
AUTO, LIGADA, timer_expira pulse -> DESCENDO, timer_clr=1; infravermelho re-asserted at brilho=100 -> SUBINDO from 100 upward.
brilho=64 held (stop ramp via param/force): lampada high 64 of every 256 cycles; short_evt and timer_expira same cycle -> one DESCENDO transition only.
rst asserted mid-SUBINDO (brilho=37) -> same cycle asynchronously: brilho 0, lampada 0, timer_clr 1, modo_auto 0.

Source files
------------

// File: rtl/controlador_iluminacao.sv
// Smart lighting controller: button debounce and press classification,
// MANUAL/AUTO mode selection, auto-shutdown timer sequencing, and a
// soft-start/soft-stop brightness ramp driving a PWM lamp output.
module controlador_iluminacao #(
  parameter int DEBOUNCE_T   = 50,
  parameter int LONG_PRESS_T = 3000,
  parameter int RAMP_STEP_T  = 100,
  parameter int PWM_BITS     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_button,
  input  logic                infravermelho,
  input  logic                ldr_escuro,
  input  logic                timer_expira,
  output logic                timer_clr,
  output logic                lampada,
  output logic [PWM_BITS-1:0] brilho,
  output logic                modo_auto,
  output logic                lamp_ativa
);

  localparam logic [1:0] DESLIGADA = 2'd0;
  localparam logic [1:0] SUBINDO   = 2'd1;
  localparam logic [1:0] LIGADA    = 2'd2;
  localparam logic [1:0] DESCENDO  = 2'd3;

  localparam int DBW = $clog2(DEBOUNCE_T + 1);
  localparam int HW  = $clog2(LONG_PRESS_T + 1);
  localparam int SW  = $clog2(RAMP_STEP_T + 1);

  localparam logic [DBW-1:0]      DB_LAST   = DBW'(DEBOUNCE_T - 1);
  localparam logic [HW-1:0]       HOLD_MAX  = HW'(LONG_PRESS_T);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(LONG_PRESS_T - 1);
  localparam logic [SW-1:0]       STEP_LAST = SW'(RAMP_STEP_T - 1);
  localparam logic [PWM_BITS-1:0] BR_MAX    = '1;

  logic                btn_s1, btn_s2;
  logic                ir_s1, ir_s2;
  logic                ldr_s1, ldr_s2;
  logic [DBW-1:0]      db_cnt;
  logic                btn_db;
  logic [HW-1:0]       hold_cnt;
  logic                long_evt;
  logic                short_evt;
  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [SW-1:0]       step_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                lamp_on;
  logic                presenca;
  logic                on_req;
  logic                off_req;

  // Two-stage synchronizers for the asynchronous inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      ir_s1  <= 1'b0;
      ir_s2  <= 1'b0;
      ldr_s1 <= 1'b0;
      ldr_s2 <= 1'b0;
    end else begin
      btn_s1 <= push_button;
      btn_s2 <= btn_s1;
      ir_s1  <= infravermelho;
      ir_s2  <= ir_s1;
      ldr_s1 <= ldr_escuro;
      ldr_s2 <= ldr_s1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_T consecutive cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_s2 == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= btn_s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Press classification: long_evt once when the hold reaches LONG_PRESS_T,
  // short_evt on release of a shorter press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      long_evt  <= 1'b0;
      short_evt <= 1'b0;
    end else begin
      long_evt  <= 1'b0;
      short_evt <= 1'b0;
      if (btn_db) begin
        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) long_evt <= 1'b1;
      end else begin
        if (hold_cnt != '0 && hold_cnt != HOLD_MAX) short_evt <= 1'b1;
        hold_cnt <= '0;
      end
    end
  end

  // Mode toggle on every long press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) modo_auto <= 1'b0;
    else if (long_evt) modo_auto <= ~modo_auto;
  end

  // Request decode; a short press and a timer expiry together form one off request
  always_comb begin
    lamp_on  = (state == SUBINDO) || (state == LIGADA);
    presenca = modo_auto & ir_s2 & ldr_s2;
    on_req   = ~lamp_on & (short_evt | presenca);
    off_req  = lamp_on & (short_evt | (modo_auto & timer_expira));
  end

  // Lamp FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      DESLIGADA: if (on_req) state_nxt = SUBINDO;
      SUBINDO: begin
        if (off_req) state_nxt = DESCENDO;
        else if (brilho == BR_MAX) state_nxt = LIGADA;
      end
      LIGADA: if (off_req) state_nxt = DESCENDO;
      DESCENDO: begin
        if (on_req) state_nxt = SUBINDO;
        else if (brilho == '0) state_nxt = DESLIGADA;
      end
      default: state_nxt = DESLIGADA;
    endcase
  end

  // Lamp FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DESLIGADA;
    else state <= state_nxt;
  end

  // Brightness ramp: one step every RAMP_STEP_T cycles, saturating at both ends;
  // a reversal restarts the step timer but keeps the current brightness
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
      brilho   <= '0;
    end else if (state_nxt != state) begin
      step_cnt <= '0;
    end else if (state == SUBINDO || state == DESCENDO) begin
      if (step_cnt == STEP_LAST) begin
        step_cnt <= '0;
        if (state == SUBINDO && brilho != BR_MAX) brilho <= brilho + 1'b1;
        else if (state == DESCENDO && brilho != '0) brilho <= brilho - 1'b1;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end else begin
      step_cnt <= '0;
    end
  end

  // Free-running PWM with registered output; full brightness is held solid on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      lampada <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      lampada <= (brilho == BR_MAX) || (pwm_cnt < brilho);
    end
  end

  assign lamp_ativa = lamp_on;
  assign timer_clr  = ~(modo_auto & lamp_on);

endmodule

// File: tb/tb_controlador_iluminacao.sv
// Directed bench for controlador_iluminacao: press-classification table,
// then hand-written ramp, AUTO, timer, PWM duty and reset sequences.
module tb_controlador_iluminacao;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push_button = 1'b0;
  logic       infravermelho = 1'b0;
  logic       ldr_escuro = 1'b0;
  logic       timer_expira = 1'b0;
  logic       timer_clr;
  logic       lampada;
  logic [7:0] brilho;
  logic       modo_auto;
  logic       lamp_ativa;

  // second instance with a slow ramp so each brightness level lasts 256 cycles
  logic       pb2 = 1'b0;
  logic       zero2 = 1'b0;
  logic       clr2;
  logic       lamp2;
  logic [7:0] brilho2;
  logic       modo2;
  logic       ativa2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  controlador_iluminacao #(
    .DEBOUNCE_T(4), .LONG_PRESS_T(20), .RAMP_STEP_T(2), .PWM_BITS(8)
  ) u_dut (
    .clk(clk), .rst(rst), .push_button(push_button),
    .infravermelho(infravermelho), .ldr_escuro(ldr_escuro),
    .timer_expira(timer_expira), .timer_clr(timer_clr), .lampada(lampada),
    .brilho(brilho), .modo_auto(modo_auto), .lamp_ativa(lamp_ativa)
  );

  controlador_iluminacao #(
    .DEBOUNCE_T(4), .LONG_PRESS_T(20), .RAMP_STEP_T(256), .PWM_BITS(8)
  ) u_pwm (
    .clk(clk), .rst(rst), .push_button(pb2),
    .infravermelho(zero2), .ldr_escuro(zero2),
    .timer_expira(zero2), .timer_clr(clr2), .lampada(lamp2),
    .brilho(brilho2), .modo_auto(modo2), .lamp_ativa(ativa2)
  );

  typedef struct {
    int unsigned len;
    logic        modo;
    logic        ativa;
    logic        clr;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int unsigned len);
    push_button = 1'b1;
    tick(int'(len));
    push_button = 1'b0;
  endtask

  task automatic wait_b(input logic [7:0] v, input int lim, output int n);
    n = 0;
    while (brilho != v && n < lim) begin
      tick(1);
      n++;
    end
    check("wait_brilho", brilho, v);
  endtask

  initial begin
    int n;
    int cnt;
    int c64;
    int h64;
    logic [7:0] snap;
    logic [7:0] prev_b;

    tbl[0] = '{len: 3,  modo: 1'b0, ativa: 1'b0, clr: 1'b1};  // glitch
    tbl[1] = '{len: 19, modo: 1'b0, ativa: 1'b1, clr: 1'b1};  // longest short press
    tbl[2] = '{len: 20, modo: 1'b1, ativa: 1'b1, clr: 1'b0};  // shortest long press
    tbl[3] = '{len: 20, modo: 1'b0, ativa: 1'b1, clr: 1'b1};
    tbl[4] = '{len: 5,  modo: 1'b0, ativa: 1'b0, clr: 1'b1};
    tbl[5] = '{len: 40, modo: 1'b1, ativa: 1'b0, clr: 1'b1};
    tbl[6] = '{len: 40, modo: 1'b0, ativa: 1'b0, clr: 1'b1};

    tick(3);
    check("rst_brilho", brilho, 0);
    check("rst_lampada", lampada, 0);
    check("rst_timer_clr", timer_clr, 1);
    check("rst_modo", modo_auto, 0);
    check("rst_ativa", lamp_ativa, 0);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 7; i++) begin
      press(tbl[i].len);
      tick(12);
      check($sformatf("tbl%0d_modo", i), modo_auto, tbl[i].modo);
      check($sformatf("tbl%0d_ativa", i), lamp_ativa, tbl[i].ativa);
      check($sformatf("tbl%0d_clr", i), timer_clr, tbl[i].clr);
    end
    wait_b(8'd0, 1000, n);
    tick(3);

    // MANUAL full ramp up and down
    press(10);
    n = 0;
    while (!lamp_ativa && n < 50) begin
      tick(1);
      n++;
    end
    check("a_start", lamp_ativa, 1);
    wait_b(8'd255, 2000, n);
    check("a_ramp_len", n, 510);
    tick(2);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (!lampada) cnt++;
    end
    check("a_full_lamp_zeros", cnt, 0);
    check("a_full_brilho", brilho, 255);
    timer_expira = 1'b1;
    tick(1);
    timer_expira = 1'b0;
    tick(2);
    check("a_manual_timer_ignored", lamp_ativa, 1);
    press(10);
    tick(12);
    check("a_off_ativa", lamp_ativa, 0);
    wait_b(8'd0, 1000, n);
    tick(3);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (lampada) cnt++;
    end
    check("a_off_lamp_ones", cnt, 0);
    check("a_off_brilho", brilho, 0);

    // AUTO via long press, presence turns lamp on
    press(30);
    tick(12);
    check("b_modo", modo_auto, 1);
    check("b_ativa_off", lamp_ativa, 0);
    tick(50);
    check("b_modo_once", modo_auto, 1);
    infravermelho = 1'b1;
    ldr_escuro = 1'b1;
    tick(5);
    check("b_presence_on", lamp_ativa, 1);
    check("b_timer_released", timer_clr, 0);
    infravermelho = 1'b0;
    wait_b(8'd255, 2000, n);
    tick(3);
    check("b_ligada", lamp_ativa, 1);
    timer_expira = 1'b1;
    tick(1);
    timer_expira = 1'b0;
    check("b_expire_off", lamp_ativa, 0);
    check("b_expire_clr", timer_clr, 1);
    wait_b(8'd100, 1000, n);
    infravermelho = 1'b1;
    n = 0;
    while (!lamp_ativa && n < 10) begin
      tick(1);
      n++;
    end
    check("b_reverse", lamp_ativa, 1);
    check("b_reverse_brilho", brilho, 99);
    tick(4);
    check("b_reverse_up", brilho, 101);

    // short press and timer expiry in the same cycle
    infravermelho = 1'b0;
    tick(4);
    press(10);
    tick(7);
    timer_expira = 1'b1;
    tick(1);
    timer_expira = 1'b0;
    check("c_same_off", lamp_ativa, 0);
    check("c_same_clr", timer_clr, 1);
    snap = brilho;
    tick(20);
    check("c_no_double", lamp_ativa, 0);
    check("c_falling", 32'(brilho < snap), 1);

    // asynchronous reset mid-ramp
    wait_b(8'd0, 1000, n);
    infravermelho = 1'b1;
    wait_b(8'd37, 200, n);
    check("e_pre_ativa", lamp_ativa, 1);
    #2 rst = 1'b1;
    #1;
    check("e_brilho", brilho, 0);
    check("e_lampada", lampada, 0);
    check("e_timer_clr", timer_clr, 1);
    check("e_modo", modo_auto, 0);
    check("e_ativa", lamp_ativa, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    infravermelho = 1'b0;
    ldr_escuro = 1'b0;
    tick(3);
    check("e_after_brilho", brilho, 0);

    // PWM duty at a held brightness of 64
    pb2 = 1'b1;
    tick(10);
    pb2 = 1'b0;
    c64 = 0;
    h64 = 0;
    n = 0;
    prev_b = brilho2;
    while (brilho2 != 8'd65 && n < 20000) begin
      tick(1);
      n++;
      if (prev_b == 8'd64) begin
        c64++;
        if (lamp2) h64++;
      end
      prev_b = brilho2;
    end
    check("d_reached_65", brilho2, 65);
    check("d_window", c64, 256);
    check("d_duty", h64, 64);
    check("d_ativa", ativa2, 1);
    check("d_modo", modo2, 0);
    check("d_clr", clr2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
